// File: rtl/stream_sink.sv
// stream_sink: enable-strobed receive endpoint with show-ahead FIFO.
// Optional sequence checker: define STREAM_SINK_SEQ_CHECK_EN.
module stream_sink #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [LW-1:0]    level_o,
  output logic             overflow_o,
  output logic             seq_err_o,
  output logic [15:0]      err_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [LW-1:0]    r_level;
  logic             r_ovf;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  assign w_pop   = valid_o && ready_i;
  assign w_push  = enable_i && (r_level != FULL || w_pop);
  assign w_drop  = enable_i && !w_push;

  assign ready_o    = (r_level != FULL);
  assign valid_o    = (r_level != '0);
  assign level_o    = r_level;
  assign data_o     = r_mem[r_rd];
  assign overflow_o = r_ovf;

  // Storage array; cleared on reset so data_o reads 0.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr] <= data_i;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)
        r_level <= r_level + LW'(1);
      else if (w_pop && !w_push)
        r_level <= r_level - LW'(1);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

`ifdef STREAM_SINK_SEQ_CHECK_EN
  logic [WIDTH-1:0] r_exp;
  logic             r_armed;
  logic             r_seq_err;
  logic [15:0]      r_err_cnt;
  logic             w_mis;

  assign w_mis       = w_push && r_armed && (data_i != r_exp);
  assign seq_err_o   = r_seq_err;
  assign err_count_o = r_err_cnt;

  // Track expected next word; resync after every mismatch.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_exp     <= '0;
      r_armed   <= 1'b0;
      r_seq_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_seq_err <= w_mis;
      if (w_push) begin
        r_exp   <= data_i + WIDTH'(1);
        r_armed <= 1'b1;
      end
      if (w_mis && r_err_cnt != 16'hFFFF)
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end
`else
  assign seq_err_o   = 1'b0;
  assign err_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_stream_sink.sv
// tb_stream_sink: queue-based model plus directed vectors.
// Follows STREAM_SINK_SEQ_CHECK_EN for checker expectations.
module tb_stream_sink;

`ifdef STREAM_SINK_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rdy = 1'b0;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic [2:0] level_o;
  logic       overflow_o;
  logic       seq_err_o;
  logic [15:0] err_count_o;
  bit         run = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [7:0] m_q[$];
  bit         m_ovf;
  bit         m_armed;
  logic [7:0] m_exp;
  bit         m_serr;
  int         m_cnt;
  logic [7:0] got[$];

  stream_sink #(.WIDTH(8), .DEPTH(4)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .enable_i(en), .data_i(din),
    .ready_o(ready_o), .data_o(data_o),
    .valid_o(valid_o), .ready_i(rdy),
    .level_o(level_o),
    .overflow_o(overflow_o),
    .seq_err_o(seq_err_o),
    .err_count_o(err_count_o)
  );

  initial begin
    wait (run);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_ovf = 0; m_armed = 0; m_exp = 8'h00;
    m_serr = 0; m_cnt = 0;
  endtask

  task automatic m_step(input bit e, input logic [7:0] d,
                        input bit r);
    bit pop, push;
    pop  = (m_q.size() != 0) && r;
    push = e && (m_q.size() < 4 || pop);
    m_serr = 0;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(d);
    if (e && !push) m_ovf = 1;
    if (SEQ_EN && push) begin
      if (m_armed && d != m_exp) begin
        m_serr = 1;
        if (m_cnt != 65535) m_cnt++;
      end
      m_exp = d + 8'd1;
      m_armed = 1;
    end
  endtask

  task automatic cyc(input bit e, input logic [7:0] d,
                     input bit r);
    en = e; din = d; rdy = r;
    #1;
    if (valid_o && r) got.push_back(data_o);
    @(posedge clk);
    #1;
    m_step(e, d, r);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " valid"}, valid_o, 0);
    chk({nm, " ready"}, ready_o, 1);
    chk({nm, " level"}, level_o, 0);
    chk({nm, " data"}, data_o, 0);
    chk({nm, " ovf"}, overflow_o, 0);
    chk({nm, " serr"}, seq_err_o, 0);
    chk({nm, " cnt"}, err_count_o, 0);
  endtask

  task automatic do_reset();
    en = 0; rdy = 0;
    #1 rstn = 0;
    m_reset();
    #1 chk_reset_vals("rst");
    #1 rstn = 1;
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    chk("cmp level", level_o, m_q.size());
    chk("cmp valid", valid_o, m_q.size() != 0);
    chk("cmp ready", ready_o, m_q.size() != 4);
    if (m_q.size() != 0) chk("cmp data", data_o, m_q[0]);
    chk("cmp ovf", overflow_o, m_ovf);
    chk("cmp serr", seq_err_o, m_serr);
    chk("cmp cnt", err_count_o, m_cnt);
  end

  initial begin
    m_reset();
    #3 chk_reset_vals("por");
    rstn = 1;
    run = 1;

    // ordered buffering
    cyc(1, 8'h10, 0);
    cyc(1, 8'h11, 0);
    cyc(1, 8'h12, 0);
    chk("t2 level", level_o, 3);
    chk("t2 head", data_o, 8'h10);
    cyc(0, 8'h00, 1);
    chk("t2 pop1", data_o, 8'h11);
    cyc(0, 8'h00, 1);
    chk("t2 pop2", data_o, 8'h12);
    cyc(0, 8'h00, 1);
    chk("t2 valid", valid_o, 0);
    chk("t2 empty", level_o, 0);
    chk("t2 order n", got.size(), 3);
    if (got.size() == 3) begin
      chk("t2 o0", got[0], 8'h10);
      chk("t2 o2", got[2], 8'h12);
    end

    // full, overflow, push-through
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 8'(i), 0);
    chk("t3 ready", ready_o, 0);
    cyc(1, 8'h04, 0);
    chk("t3 ovf", overflow_o, 1);
    chk("t3 lvl", level_o, 4);
    cyc(1, 8'h05, 1);
    chk("t3 lvl2", level_o, 4);
    chk("t3 head", data_o, 8'h01);
    chk("t3 ovf2", overflow_o, 1);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    chk("t3 tail", data_o, 8'h05);

    // sequence checker
    do_reset();
    cyc(1, 8'hFE, 1);
    chk("t4 fe", seq_err_o, 0);
    cyc(1, 8'hFF, 1);
    chk("t4 ff", seq_err_o, 0);
    cyc(1, 8'h00, 1);
    chk("t4 wrap", seq_err_o, 0);
    cyc(1, 8'h05, 1);
    chk("t4 err", seq_err_o, SEQ_EN ? 1 : 0);
    chk("t4 cnt", err_count_o, SEQ_EN ? 1 : 0);
    cyc(1, 8'h06, 1);
    chk("t4 ok", seq_err_o, 0);
    chk("t4 cnt2", err_count_o, SEQ_EN ? 1 : 0);
    cyc(0, 8'h00, 1);

    // mid-operation reset
    do_reset();
    cyc(1, 8'h01, 0);
    cyc(1, 8'h03, 0);
    cyc(1, 8'h05, 0);
    chk("t5 lvl", level_o, 3);
    chk("t5 cnt", err_count_o, SEQ_EN ? 2 : 0);
    do_reset();
    cyc(1, 8'h40, 1);
    chk("t5 serr", seq_err_o, 0);
    chk("t5 lvl1", level_o, 1);
    chk("t5 data", data_o, 8'h40);
    cyc(0, 8'h00, 1);

    // pointer wrap, continuous streaming
    do_reset();
    got.delete();
    for (int i = 0; i < 12; i++) begin
      cyc(1, 8'(i), 1);
      if (level_o > 1) chk("t6 lvl", level_o, 1);
    end
    cyc(0, 8'h00, 1);
    chk("t6 n", got.size(), 12);
    for (int i = 0; i < got.size(); i++)
      chk("t6 ord", got[i], i);
    chk("t6 ovf", overflow_o, 0);
    chk("t6 cnt", err_count_o, 0);
    chk("t6 empty", valid_o, 0);

    #2;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
